// File: rtl/physics_pkg.sv
// Shared types and helpers for the mass-spring physics blocks.
// Holds the integrator state enum, default widths and saturation limits.
package physics_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VEL,
    POS,
    DONE
  } integrator_state;

  localparam int DEF_POSITION_SIZE = 16;
  localparam int DEF_VELOCITY_SIZE = 16;
  localparam int DEF_FORCE_SIZE    = 16;
  localparam int DEF_ACCUM_SIZE    = 24;
  localparam int DEF_DT_SHIFT      = 4;
  localparam int DEF_MASS_SHIFT    = 0;
  localparam int DEF_GRAVITY_Y     = -16;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: adds two IN_SIZE operands without overflow,
// then clamps the exact sum into the signed OUT_SIZE range.
module sat_add
  import physics_pkg::*;
#(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 16
) (
  input  logic [IN_SIZE-1:0]  a,
  input  logic [IN_SIZE-1:0]  b,
  output logic [OUT_SIZE-1:0] sum
);

  localparam logic signed [IN_SIZE:0] HI = (IN_SIZE + 1)'(sat_max(OUT_SIZE));
  localparam logic signed [IN_SIZE:0] LO = (IN_SIZE + 1)'(sat_min(OUT_SIZE));

  logic signed [IN_SIZE:0] wide;

  assign wide = (IN_SIZE + 1)'($signed(a)) + (IN_SIZE + 1)'($signed(b));

  always_comb begin
    if (wide > HI) begin
      sum = OUT_SIZE'(HI);
    end else if (wide < LO) begin
      sum = OUT_SIZE'(LO);
    end else begin
      sum = OUT_SIZE'(wide);
    end
  end

endmodule

// File: rtl/point_mass_integrator.sv
// Per-mass-point force accumulator and semi-implicit Euler integrator.
// Optional floor clamp on y is enabled by defining FLOOR_CLAMP_EN.
module point_mass_integrator
  import physics_pkg::*;
#(
  parameter int POSITION_SIZE = DEF_POSITION_SIZE,
  parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
  parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
  parameter int ACCUM_SIZE    = DEF_ACCUM_SIZE,
  parameter int DT_SHIFT      = DEF_DT_SHIFT,
  parameter int MASS_SHIFT    = DEF_MASS_SHIFT,
  parameter logic signed [ACCUM_SIZE-1:0]    GRAVITY_Y = ACCUM_SIZE'(DEF_GRAVITY_Y),
  parameter logic signed [POSITION_SIZE-1:0] FLOOR_Y   = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     init_valid,
  input  logic [POSITION_SIZE-1:0] init_pos_x,
  input  logic [POSITION_SIZE-1:0] init_pos_y,
  input  logic [VELOCITY_SIZE-1:0] init_vel_x,
  input  logic [VELOCITY_SIZE-1:0] init_vel_y,
  input  logic                     force_valid,
  input  logic [FORCE_SIZE-1:0]    force_x,
  input  logic [FORCE_SIZE-1:0]    force_y,
  output logic                     force_ready,
  input  logic                     step_in,
  output logic [POSITION_SIZE-1:0] pos_x,
  output logic [POSITION_SIZE-1:0] pos_y,
  output logic [VELOCITY_SIZE-1:0] vel_x,
  output logic [VELOCITY_SIZE-1:0] vel_y,
  output logic                     result_valid,
  output logic                     busy
);

  localparam int VSUM_SIZE = ACCUM_SIZE + 1;
  localparam int PSUM_SIZE = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
  localparam int DV_SHIFT  = DT_SHIFT + MASS_SHIFT;
`ifdef FLOOR_CLAMP_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  integrator_state state, state_next;
  logic force_accept;

  logic signed [ACCUM_SIZE-1:0]    acc_x, acc_y, acc_sum_x, acc_sum_y;
  logic signed [ACCUM_SIZE-1:0]    force_ext_x, force_ext_y;
  logic signed [VSUM_SIZE-1:0]     vel_ext_x, vel_ext_y, dv_x, dv_y;
  logic signed [VELOCITY_SIZE-1:0] vel_sum_x, vel_sum_y, vel_next_x, vel_next_y;
  logic signed [VELOCITY_SIZE-1:0] dp_x, dp_y, vel_new_y;
  logic signed [PSUM_SIZE-1:0]     pos_ext_x, pos_ext_y, dp_ext_x, dp_ext_y;
  logic signed [POSITION_SIZE-1:0] pos_sum_x, pos_sum_y, pos_new_y;

  assign force_accept = force_valid && force_ready;
  assign force_ext_x  = ACCUM_SIZE'($signed(force_x));
  assign force_ext_y  = ACCUM_SIZE'($signed(force_y));

  // Widen by one bit so adding gravity to a saturated accumulator cannot wrap.
  assign dv_x      = VSUM_SIZE'(acc_x) >>> DV_SHIFT;
  assign dv_y      = (VSUM_SIZE'(acc_y) + VSUM_SIZE'(GRAVITY_Y)) >>> DV_SHIFT;
  assign vel_ext_x = VSUM_SIZE'($signed(vel_x));
  assign vel_ext_y = VSUM_SIZE'($signed(vel_y));

  assign dp_x      = vel_next_x >>> DT_SHIFT;
  assign dp_y      = vel_next_y >>> DT_SHIFT;
  assign dp_ext_x  = PSUM_SIZE'(dp_x);
  assign dp_ext_y  = PSUM_SIZE'(dp_y);
  assign pos_ext_x = PSUM_SIZE'($signed(pos_x));
  assign pos_ext_y = PSUM_SIZE'($signed(pos_y));

  sat_add #(.IN_SIZE(ACCUM_SIZE), .OUT_SIZE(ACCUM_SIZE)) u_acc_x (
    .a(acc_x), .b(force_ext_x), .sum(acc_sum_x)
  );
  sat_add #(.IN_SIZE(ACCUM_SIZE), .OUT_SIZE(ACCUM_SIZE)) u_acc_y (
    .a(acc_y), .b(force_ext_y), .sum(acc_sum_y)
  );
  sat_add #(.IN_SIZE(VSUM_SIZE), .OUT_SIZE(VELOCITY_SIZE)) u_vel_x (
    .a(vel_ext_x), .b(dv_x), .sum(vel_sum_x)
  );
  sat_add #(.IN_SIZE(VSUM_SIZE), .OUT_SIZE(VELOCITY_SIZE)) u_vel_y (
    .a(vel_ext_y), .b(dv_y), .sum(vel_sum_y)
  );
  sat_add #(.IN_SIZE(PSUM_SIZE), .OUT_SIZE(POSITION_SIZE)) u_pos_x (
    .a(pos_ext_x), .b(dp_ext_x), .sum(pos_sum_x)
  );
  sat_add #(.IN_SIZE(PSUM_SIZE), .OUT_SIZE(POSITION_SIZE)) u_pos_y (
    .a(pos_ext_y), .b(dp_ext_y), .sum(pos_sum_y)
  );

  always_comb begin
    pos_new_y = pos_sum_y;
    vel_new_y = vel_next_y;
    if (FLOOR_EN && (pos_sum_y < FLOOR_Y)) begin
      pos_new_y = FLOOR_Y;
      vel_new_y = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (step_in && !init_valid) state_next = VEL;
      VEL:     state_next = POS;
      POS:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    force_ready  = (state == IDLE);
    busy         = (state != IDLE);
    result_valid = (state == DONE);
  end

  // Outputs are written on the POS->DONE edge so they appear with result_valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_x      <= '0;
      acc_y      <= '0;
      vel_next_x <= '0;
      vel_next_y <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      vel_x      <= '0;
      vel_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_valid) begin
            pos_x <= init_pos_x;
            pos_y <= init_pos_y;
            vel_x <= init_vel_x;
            vel_y <= init_vel_y;
            acc_x <= '0;
            acc_y <= '0;
          end else if (force_accept) begin
            acc_x <= acc_sum_x;
            acc_y <= acc_sum_y;
          end
        end
        VEL: begin
          vel_next_x <= vel_sum_x;
          vel_next_y <= vel_sum_y;
          acc_x      <= '0;
          acc_y      <= '0;
        end
        POS: begin
          pos_x <= pos_sum_x;
          pos_y <= pos_new_y;
          vel_x <= vel_next_x;
          vel_y <= vel_new_y;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
